// File: rtl/vc_buffer.sv
// Virtual-channel flit buffer: circular FIFO with credit-based flow control and
// a delayed credit_return pulse for each flit that leaves.
module vc_buffer #(
  parameter int unsigned FLIT_SIZE    = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CREDIT_DELAY = 16,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [FLIT_SIZE-1:0] flit,
  input  logic                 load,
  input  logic                 next_router_credit,
  output logic [FLIT_SIZE-1:0] flit_buff,
  output logic                 is_new,
  output logic                 credit,
  output logic                 credit_return,
  output logic [CW-1:0]        count,
  output logic                 overflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [FLIT_SIZE-1:0]    r_mem [DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           w_count_d;
  logic                    r_overflow;
  logic [CREDIT_DELAY-1:0] r_cr_pipe;
  logic                    r_credit_return;
  logic                    w_push;
  logic                    w_pop;

  // credit comes only from registered count, so a pop never frees a slot for
  // a load in the same cycle.
  assign credit = (r_count != CW'(DEPTH));
  assign is_new = (r_count != '0);
  assign w_push = load & credit;
  assign w_pop  = next_router_credit & is_new;

  always_comb begin
    w_count_d = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_d;
      if (load && !credit) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= flit;
  end

  // Pop enters stage 0 on its own edge; the output flop adds the final cycle,
  // so the pulse rises CREDIT_DELAY edges after the departure edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cr_pipe       <= '0;
      r_credit_return <= 1'b0;
    end else begin
      r_cr_pipe[0] <= w_pop;
      for (int i = 1; i < CREDIT_DELAY; i++) begin
        r_cr_pipe[i] <= r_cr_pipe[i-1];
      end
      r_credit_return <= r_cr_pipe[CREDIT_DELAY-1];
    end
  end

  assign flit_buff     = reset ? '0 : r_mem[r_rd_ptr];
  assign credit_return = r_credit_return;
  assign count         = r_count;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_vc_buffer.sv
// Directed self-checking bench for vc_buffer (FLIT_SIZE=8, DEPTH=4, CREDIT_DELAY=3).
module tb_vc_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] flit;
  logic       load;
  logic       next_router_credit;
  logic [7:0] flit_buff;
  logic       is_new;
  logic       credit;
  logic       credit_return;
  logic [2:0] count;
  logic       overflow;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  vc_buffer #(
    .FLIT_SIZE   (8),
    .DEPTH       (4),
    .CREDIT_DELAY(3)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .flit              (flit),
    .load              (load),
    .next_router_credit(next_router_credit),
    .flit_buff         (flit_buff),
    .is_new            (is_new),
    .credit            (credit),
    .credit_return     (credit_return),
    .count             (count),
    .overflow          (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".is_new"}, 32'(is_new), 32'd0);
    chk({tag, ".credit"}, 32'(credit), 32'd1);
    chk({tag, ".credit_return"}, 32'(credit_return), 32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    next_router_credit = 1'b0;
    flit = 8'h00;

    tick();
    chk_reset_vals("in_reset");
    chk("in_reset.flit_buff", 32'(flit_buff), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk_reset_vals("post_reset");

    // Fill to full with no downstream credit.
    for (int i = 0; i < 4; i++) begin
      flit = 8'(8'h11 * (i + 1));
      load = 1'b1;
      tick();
      chk("fill.count", 32'(count), 32'(i + 1));
    end
    load = 1'b0;
    chk("full.credit", 32'(credit), 32'd0);
    chk("full.is_new", 32'(is_new), 32'd1);
    chk("full.head", 32'(flit_buff), 32'h11);

    // Load while full is dropped and flags overflow.
    flit = 8'h55;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("ovf.overflow", 32'(overflow), 32'd1);
    chk("ovf.count", 32'(count), 32'd4);
    chk("ovf.head", 32'(flit_buff), 32'h11);

    // Load with pop while full: pop happens, load is dropped (edge E).
    flit = 8'h66;
    load = 1'b1;
    next_router_credit = 1'b1;
    tick();
    load = 1'b0;
    chk("popfull.count", 32'(count), 32'd3);
    chk("popfull.head", 32'(flit_buff), 32'h22);
    chk("popfull.cr", 32'(credit_return), 32'd0);
    tick();
    chk("drain1.count", 32'(count), 32'd2);
    chk("drain1.head", 32'(flit_buff), 32'h33);
    chk("drain1.cr", 32'(credit_return), 32'd0);
    tick();
    chk("drain2.count", 32'(count), 32'd1);
    chk("drain2.head", 32'(flit_buff), 32'h44);
    chk("drain2.cr", 32'(credit_return), 32'd0);
    tick();
    chk("drain3.count", 32'(count), 32'd0);
    chk("drain3.is_new", 32'(is_new), 32'd0);
    chk("drain3.cr", 32'(credit_return), 32'd1);
    next_router_credit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("burst.cr", 32'(credit_return), 32'd1);
    end
    tick();
    chk("burst_end.cr", 32'(credit_return), 32'd0);
    chk("sticky.overflow", 32'(overflow), 32'd1);
    chk("sticky.count", 32'(count), 32'd0);

    reset = 1'b1;
    #1;
    chk("clr.overflow", 32'(overflow), 32'd0);
    tick();
    reset = 1'b0;

    // Spurious downstream credit on an empty queue.
    next_router_credit = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("spur.count", 32'(count), 32'd0);
      chk("spur.cr", 32'(credit_return), 32'd0);
    end
    next_router_credit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("spur_tail.cr", 32'(credit_return), 32'd0);
    end

    // Single pop latency: pulse only after edge N+3.
    flit = 8'hA1;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("single.head", 32'(flit_buff), 32'hA1);
    chk("single.is_new", 32'(is_new), 32'd1);
    next_router_credit = 1'b1;
    tick();
    next_router_credit = 1'b0;
    chk("single.popped", 32'(is_new), 32'd0);
    chk("single.cr0", 32'(credit_return), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("single.cr", 32'(credit_return), 32'(k == 3));
    end

    // Simultaneous push/pop at count=2, pointers wrap.
    load = 1'b1;
    flit = 8'h01;
    tick();
    flit = 8'h02;
    tick();
    chk("simul.pre_count", 32'(count), 32'd2);
    chk("simul.pre_head", 32'(flit_buff), 32'h01);
    next_router_credit = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      flit = 8'(k + 2);
      tick();
      chk("simul.count", 32'(count), 32'd2);
      chk("simul.head", 32'(flit_buff), 32'(k + 1));
      chk("simul.cr", 32'(credit_return), 32'(k >= 4));
    end
    load = 1'b0;
    tick();
    chk("simul.tail_head", 32'(flit_buff), 32'h0C);
    tick();
    next_router_credit = 1'b0;
    chk("simul.empty", 32'(is_new), 32'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("simul.flushed_cr", 32'(credit_return), 32'd0);

    // Reset mid-stream with pulses still in the credit pipeline.
    load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flit = 8'(8'hC1 + i);
      tick();
    end
    chk("mid.count3", 32'(count), 32'd3);
    next_router_credit = 1'b1;
    flit = 8'hC4;
    tick();
    flit = 8'hC5;
    tick();
    load = 1'b0;
    next_router_credit = 1'b0;
    chk("mid.count", 32'(count), 32'd3);
    chk("mid.cr", 32'(credit_return), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    chk("mid_reset.flit_buff", 32'(flit_buff), 32'd0);
    tick();
    #2;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("after_reset.cr", 32'(credit_return), 32'd0);
      chk("after_reset.count", 32'(count), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
